// File: rtl/istft_ola_if.sv
// Handshake/bus bundle between the ISTFT core, the overlap-add stage and the audio/DAC side.
// Latency: n/a (wires only).
// Backpressure: none in-band; the upstream producer gates whole frames on room.
// Ports: master = upstream/consumer side (drives frame_start, samp_vld, samp_in, aud_req);
//        slave  = istft_ola (drives aud_out, aud_vld, room, frame_done, overflow, underflow).
interface istft_ola_if;
  logic               frame_start;
  logic               samp_vld;
  logic signed [15:0] samp_in;
  logic               aud_req;
  logic signed [15:0] aud_out;
  logic               aud_vld;
  logic               room;
  logic               frame_done;
  logic               overflow;
  logic               underflow;

  modport master (
    output frame_start, samp_vld, samp_in, aud_req,
    input  aud_out, aud_vld, room, frame_done, overflow, underflow
  );

  modport slave (
    input  frame_start, samp_vld, samp_in, aud_req,
    output aud_out, aud_vld, room, frame_done, overflow, underflow
  );
endinterface

// File: rtl/istft_ola.sv
// 50 % overlap-add of ISTFT output frames into an output FIFO that the audio side pops.
// Latency: sample readable in the FIFO 2 cycles after its samp_vld; pop data 1 cycle after aud_req.
// Backpressure: room tells upstream a whole frame fits; pushes into a full FIFO are dropped (overflow).
// Ports: clk, rst_n (async active-low); bus (istft_ola_if.slave):
//   frame_start/samp_vld/samp_in in, aud_req in, aud_out/aud_vld out, room/frame_done out,
//   overflow/underflow sticky error flags (cleared only by reset).
module istft_ola #(
  parameter int FRAME_LEN  = 1024,
  parameter int HOP        = FRAME_LEN / 2,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  istft_ola_if.slave  bus
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(HOP);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic signed [15:0] olap [HOP];

  // add/saturate pipeline register feeding the FIFO write port
  logic               push_vld;
  logic signed [15:0] push_dat;

  // output FIFO
  logic signed [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  // ------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------
  logic [HW-1:0]      k;
  logic               accept;
  logic signed [16:0] sum17;
  logic signed [15:0] sum_sat;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push_ok;
  logic [CW-1:0]      count_nxt;
  logic               idle_nxt;
  logic               room_nxt;

  // Position within the current half; both halves index olap the same way.
  assign k      = idx[HW-1:0];
  assign accept = bus.samp_vld && (state != IDLE);

  always_comb begin
    sum17   = {olap[k][15], olap[k]} + {bus.samp_in[15], bus.samp_in};
    sum_sat = sum17[15:0];
    // Sign bits disagree only when the 17-bit sum left the 16-bit range.
    if (sum17[16] != sum17[15]) begin
      sum_sat = sum17[16] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = bus.aud_req && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push_ok = push_vld && (!full || pop);

  assign count_nxt = count + CW'(push_ok) - CW'(pop);

  // room is registered, so it is derived from next-state and next-occupancy.
  assign idle_nxt = ((state == IDLE) && !bus.frame_start) ||
                    ((state == SECOND) && accept && (&idx));
  assign room_nxt = idle_nxt && ((CW'(FIFO_DEPTH) - count_nxt) >= CW'(HOP));

  // ------------------------------------------------------------------
  // Frame FSM, overlap buffer and add/saturate stage
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      push_vld       <= 1'b0;
      push_dat       <= '0;
      bus.frame_done <= 1'b0;
      bus.room       <= 1'b1;
      for (int i = 0; i < HOP; i++) begin
        olap[i] <= '0;
      end
    end else begin
      push_vld       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.room       <= room_nxt;

      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state <= FIRST;
            idx   <= '0;
          end
        end

        FIRST: begin
          if (accept) begin
            push_vld <= 1'b1;
            push_dat <= sum_sat;
            idx      <= idx + IW'(1);
            if (&k) begin
              state <= SECOND;
            end
          end
        end

        SECOND: begin
          if (accept) begin
            olap[k] <= bus.samp_in;
            idx     <= idx + IW'(1);
            if (&idx) begin
              state          <= IDLE;
              bus.frame_done <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output FIFO storage (no reset: pointers and count define validity)
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // ------------------------------------------------------------------
  // Output FIFO control, pop port and sticky error flags
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.aud_out   <= '0;
      bus.aud_vld   <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.aud_vld <= pop;
      count       <= count_nxt;

      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      // At full with a simultaneous push, wr_ptr == rd_ptr: the read here
      // sees the old entry because the write lands on this same edge.
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        bus.aud_out <= mem[rd_ptr];
      end

      if (push_vld && full && !pop) begin
        bus.overflow <= 1'b1;
      end

      if (bus.aud_req && empty) begin
        bus.underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_istft_ola.sv
// Self-checking bench for istft_ola: reference model feeds an expected-sample queue,
// pops from the DUT are compared against it, plus spot checks against fixed values.
module tb_istft_ola;

  localparam int FL = 1024;
  localparam int HP = FL / 2;
  localparam int FD = 1024;
  localparam logic signed [15:0] NEG_MAX = 16'sh8000;
  localparam logic signed [15:0] POS_MAX = 16'sh7FFF;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  istft_ola_if bus();

  istft_ola #(
    .FRAME_LEN (FL),
    .HOP       (HP),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;

  always @(posedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  // Reference model state
  int                 mstate;
  int                 midx;
  int                 mcount;
  logic signed [15:0] molap [HP];
  logic signed [15:0] exp_q [$];

  function automatic logic signed [15:0] sat16(input int s);
    if (s > 32767)  return POS_MAX;
    if (s < -32768) return NEG_MAX;
    return s[15:0];
  endfunction

  task automatic model_reset();
    mstate = 0;
    midx   = 0;
    mcount = 0;
    exp_q.delete();
    for (int i = 0; i < HP; i++) molap[i] = '0;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    if (mstate == 0) begin
      mstate = 1;
      midx   = 0;
    end
  endtask

  // One sample; with pop_with the audio side pops in the cycle the push is written.
  task automatic send_sample(input logic signed [15:0] v, input bit pop_with);
    logic signed [15:0] pushv;
    logic signed [15:0] e;
    bit do_push;
    do_push     = 1'b0;
    pushv       = '0;
    bus.samp_in  = v;
    bus.samp_vld = 1'b1;
    @(posedge clk); #1;
    bus.samp_vld = 1'b0;
    if (mstate == 1) begin
      pushv   = sat16(int'(v) + int'(molap[midx]));
      do_push = 1'b1;
    end else if (mstate == 2) begin
      molap[midx-HP] = v;
    end
    if (mstate != 0) begin
      midx++;
      if (mstate == 1 && midx == HP) mstate = 2;
      else if (mstate == 2 && midx == FL) mstate = 0;
    end
    if (pop_with) begin
      bus.aud_req = 1'b1;
      @(posedge clk); #1;
      bus.aud_req = 1'b0;
      e = exp_q.pop_front();
      mcount--;
      n_checks++;
      if (bus.aud_vld !== 1'b1 || bus.aud_out !== e)
        $display("FAIL pop_with_push: vld=%b out=%0d, expected vld=1 out=%0d", bus.aud_vld, bus.aud_out, e);
      else n_pass++;
    end
    if (do_push) begin
      if (mcount < FD) begin
        exp_q.push_back(pushv);
        mcount++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Sample 0 = s0, samples 1..HP-1 = rest, samples HP.. = second; n samples total.
  // A frame_start pulse is injected before sample restart_at (ignored mid-frame).
  task automatic send_frame(input logic signed [15:0] s0, input logic signed [15:0] rest,
                            input logic signed [15:0] second, input int n, input int restart_at);
    start_frame();
    for (int i = 0; i < n; i++) begin
      if (i == restart_at) start_frame();
      send_sample((i == 0) ? s0 : ((i < HP) ? rest : second), 1'b0);
    end
    idle(2);
  endtask

  task automatic pop_n(input int n, input string tag,
                       output logic signed [15:0] first_v, output logic signed [15:0] last_v);
    first_v = '0;
    last_v  = '0;
    for (int i = 0; i < n; i++) begin
      logic signed [15:0] e;
      bit has;
      has = (exp_q.size() > 0);
      e   = '0;
      if (has) begin
        e = exp_q.pop_front();
        mcount--;
      end
      bus.aud_req = 1'b1;
      @(posedge clk); #1;
      bus.aud_req = 1'b0;
      n_checks++;
      if (has) begin
        if (bus.aud_vld !== 1'b1 || bus.aud_out !== e)
          $display("FAIL %s pop %0d: vld=%b out=%0d, expected vld=1 out=%0d", tag, i, bus.aud_vld, bus.aud_out, e);
        else n_pass++;
      end else begin
        if (bus.aud_vld !== 1'b0)
          $display("FAIL %s pop %0d on empty: vld=%b, expected 0", tag, i, bus.aud_vld);
        else n_pass++;
      end
      if (i == 0) first_v = bus.aud_out;
      last_v = bus.aud_out;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (bus.aud_out !== 16'sd0 || bus.aud_vld !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.room !== 1'b1)
      $display("FAIL %s: out=%0d vld=%b done=%b ovf=%b unf=%b room=%b, expected 0 0 0 0 0 1",
               tag, bus.aud_out, bus.aud_vld, bus.frame_done, bus.overflow, bus.underflow, bus.room);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.samp_vld    = 1'b0;
    bus.samp_in     = '0;
    bus.aud_req     = 1'b0;
    model_reset();
    idle(3);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    idle(2);
    check_reset_outputs("after_release");
  endtask

  task automatic test_underflow();
    bus.aud_req = 1'b1;
    @(posedge clk); #1;
    bus.aud_req = 1'b0;
    n_checks++;
    if (bus.aud_vld !== 1'b0 || bus.aud_out !== 16'sd0 || bus.underflow !== 1'b1)
      $display("FAIL underflow: vld=%b out=%0d unf=%b, expected 0 0 1", bus.aud_vld, bus.aud_out, bus.underflow);
    else n_pass++;
  endtask

  task automatic test_impulse();
    logic signed [15:0] f, l;
    int base;
    send_sample(16'sd999, 1'b0);   // stray sample while idle: must be ignored
    idle(2);
    base = fd_cnt;
    start_frame();
    n_checks++;
    if (bus.room !== 1'b0) $display("FAIL room_after_start: room=%b, expected 0", bus.room);
    else n_pass++;
    for (int i = 0; i < FL; i++) send_sample((i == 0) ? 16'sd1000 : 16'sd0, 1'b0);
    idle(2);
    n_checks++;
    if (fd_cnt - base !== 1) $display("FAIL frame_done_count: got %0d, expected 1", fd_cnt - base);
    else n_pass++;
    n_checks++;
    if (bus.room !== 1'b1) $display("FAIL room_after_frame: room=%b, expected 1", bus.room);
    else n_pass++;
    pop_n(HP, "impulse", f, l);
    n_checks++;
    if (f !== 16'sd1000 || l !== 16'sd0)
      $display("FAIL impulse_values: first=%0d last=%0d, expected 1000 0", f, l);
    else n_pass++;
  endtask

  task automatic test_overlap();
    logic signed [15:0] f, l;
    send_frame(16'sd100, 16'sd100, 16'sd100, FL, 700);   // restart pulse in SECOND is ignored
    send_frame(16'sd50, 16'sd50, 16'sd50, FL, -1);
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.room !== 1'b0)
      $display("FAIL full_no_overflow: ovf=%b room=%b, expected 0 0", bus.overflow, bus.room);
    else n_pass++;
    pop_n(HP, "overlap_a", f, l);
    n_checks++;
    if (f !== 16'sd100 || l !== 16'sd100) $display("FAIL overlap_a: first=%0d last=%0d, expected 100", f, l);
    else n_pass++;
    pop_n(HP, "overlap_b", f, l);
    n_checks++;
    if (f !== 16'sd150 || l !== 16'sd150) $display("FAIL overlap_b: first=%0d last=%0d, expected 150", f, l);
    else n_pass++;
  endtask

  task automatic test_saturation_stress();
    logic signed [15:0] f, l;
    send_frame(16'sd0, 16'sd0, 16'sd30000, FL, -1);
    send_frame(16'sd5000, 16'sd5000, -16'sd30000, FL, -1);   // FIFO now exactly full
    start_frame();
    send_sample(-16'sd5000, 1'b1);                           // push at full with pop
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL push_pop_at_full: ovf=%b, expected 0", bus.overflow);
    else n_pass++;
    send_sample(-16'sd5000, 1'b0);                           // push at full, no pop
    idle(1);
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL overflow_set: ovf=%b, expected 1", bus.overflow);
    else n_pass++;
    for (int i = 2; i < FL; i++) send_sample((i < HP) ? -16'sd5000 : 16'sd0, 1'b0);
    idle(2);
    pop_n(HP - 1, "sat_zero", f, l);
    pop_n(HP, "sat_pos", f, l);
    n_checks++;
    if (f !== POS_MAX || l !== POS_MAX) $display("FAIL sat_pos: first=%0d last=%0d, expected 32767", f, l);
    else n_pass++;
    pop_n(1, "sat_neg", f, l);
    n_checks++;
    if (f !== NEG_MAX) $display("FAIL sat_neg: got %0d, expected -32768", f);
    else n_pass++;
    pop_n(1, "drained", f, l);   // queue empty: FIFO must be empty too
  endtask

  task automatic test_reset_midframe();
    logic signed [15:0] f, l;
    start_frame();
    for (int i = 0; i < 300; i++) send_sample(16'sd50, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    idle(3);
    check_reset_outputs("midframe_reset_hold");
    rst_n = 1'b1;
    model_reset();
    idle(2);
    send_frame(16'sd7, 16'sd7, 16'sd7, FL, -1);
    pop_n(HP + 1, "after_reset", f, l);
    n_checks++;
    if (f !== 16'sd7) $display("FAIL after_reset_passthrough: got %0d, expected 7", f);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_underflow();
    test_impulse();
    test_overlap();
    test_saturation_stress();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
